mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of grant cycles without mem_ready before abort (used only with MEM_ARBITER_TIMEOUT_EN).
REQ-002 SHALL have port clock  in  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports m0_valid/m1_valid  in  1  request from master 0 (CPU) and master 1 (DMA/debug).
REQ-005 SHALL have ports m0_ready/m1_ready  out  1  one-cycle completion pulse to the master.
REQ-006 SHALL have ports m0_addr/m1_addr, m0_wdata/m1_wdata  in  32 each, and m0_wstrb/m1_wstrb  in  4 each.
REQ-007 SHALL have port m0_insn  in  1  instruction-fetch flag; master 1 is treated as insn=0.
REQ-008 SHALL have ports m0_rdata/m1_rdata  out  32  read data, valid while the matching ready is high.
REQ-009 SHALL have ports mem_valid out 1, mem_insn out 1, mem_addr out 32, mem_wdata out 32, mem_wstrb out 4, mem_ready in 1, mem_rdata in 32, forming the shared slave bus.
REQ-010 SHALL have port err  out  1  sticky timeout flag.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT0 and GRANT1.
REQ-012 In IDLE, mem_valid SHALL be 0 and mem_ready SHALL be ignored.
REQ-013 In IDLE with exactly one mX_valid high, the next state SHALL be GRANTX.
REQ-014 In IDLE with both valids high, the grant SHALL go to the master not served last (round-robin on register last_grant).
REQ-015 In GRANTX, mem_valid, mem_addr, mem_wdata, mem_wstrb and mem_insn SHALL combinationally follow master X's signals.
REQ-016 When not granted, mem_addr, mem_wdata and mem_wstrb SHALL be driven from master 0 with mem_wstrb forced to 0.
REQ-017 In GRANTX with mem_ready=1: mX_ready=1 and mX_rdata=mem_rdata in the same cycle; the next state SHALL be IDLE and last_grant SHALL become X.
REQ-018 The other master's ready SHALL stay 0 at all times during GRANTX.
REQ-019 Arbitration latency SHALL be one cycle: from valid rising in IDLE to mem_valid high.
REQ-020 After each completion there SHALL be at least one IDLE cycle, so a new transfer cannot start in the cycle the slave clears ready.
REQ-021 If mX_valid drops in GRANTX before mem_ready (protocol violation), the FSM SHALL return to IDLE with no ready pulse and last_grant unchanged.
REQ-022 mX_rdata SHALL be mem_rdata while mX_ready=1, otherwise 0.
REQ-023 A request SHALL wait at most one other transfer before being granted (starvation-free).

Reset
REQ-024 Reset asserted SHALL immediately force: state=IDLE, last_grant=1 (master 0 wins the first tie), mem_valid=0, m0_ready=0, m1_ready=0, err=0, timeout counter=0.
REQ-025 Reset mid-grant SHALL abandon the transfer with no ready pulse to either master.
REQ-026 After reset release, the first grant SHALL occur no earlier than the next rising edge.

Configuration
REQ-027 With macro MEM_ARBITER_TIMEOUT_EN defined, an 8-bit-minimum counter SHALL clear on entering GRANTX and increment each GRANTX cycle without mem_ready.
REQ-028 With MEM_ARBITER_TIMEOUT_EN, when the counter reaches TIMEOUT-1 without mem_ready: mX_ready=1, mX_rdata=32'hFFFFFFFF, err set (sticky until reset), next state IDLE, last_grant=X.
REQ-029 With MEM_ARBITER_TIMEOUT_EN, mem_ready arriving in the same cycle as the timeout SHALL win: normal completion, err unchanged.
REQ-030 Without MEM_ARBITER_TIMEOUT_EN, no counter SHALL exist, err SHALL be constant 0, and a grant SHALL wait indefinitely for mem_ready.

Verification
REQ-031 Bench SHALL cover: m0 read addr 0x00000400, slave ready after 1 cycle with rdata 0x12345678 -> mem_valid at cycle 1, m0_ready pulse with rdata 0x12345678 at cycle 2, m1_ready stays 0.
REQ-032 Bench SHALL cover: both valid on the first cycle after reset -> m0 served first, then m1; a second simultaneous pair -> m0 then m1 again (alternation).
REQ-033 Bench SHALL cover: m1 write 0x00010000 wstrb 4'b0011 while m0 idle -> mem_wstrb=4'b0011 only during GRANT1; mem_wstrb=0 in IDLE.
REQ-034 Bench SHALL cover: reset asserted mid-GRANT0 -> mem_valid falls with no clock edge, and no ready pulse follows.
REQ-035 Bench SHALL cover (MEM_ARBITER_TIMEOUT_EN, TIMEOUT=16): slave never ready -> m0_ready on grant cycle 16 with rdata 0xFFFFFFFF and err=1; the following m1 request completes normally.
REQ-036 Bench SHALL cover: m0_valid dropped in GRANT0 before ready -> IDLE next cycle, no m0_ready, and a pending m1 is granted next.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter onto a shared memory bus (option: MEM_ARBITER_TIMEOUT_EN)
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_insn,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        mem_valid,
  output logic        mem_insn,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  // last_grant_q holds the master served most recently; the other one wins a tie
  logic   last_grant_q, last_grant_d;

  logic        gnt_active;
  logic        gnt_sel;
  logic        sel_valid;
  logic        done_ok;
  logic        done_to;
  logic        done;
  logic [31:0] resp_data;

  assign gnt_active = (state_q != IDLE);
  assign gnt_sel    = (state_q == GRANT1);
  assign sel_valid  = gnt_sel ? m1_valid : m0_valid;

  // A completion only counts while the granted master still holds its request
  assign done_ok = gnt_active && sel_valid && mem_ready;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // mem_ready in the expiry cycle takes precedence over the timeout
  assign done_to = gnt_active && sel_valid && !mem_ready && (cnt_q == CW'(TIMEOUT - 1));

  // Wait counter is held at zero in IDLE so every grant starts counting from zero
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!mem_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (done_to) begin
      err_d = 1'b1;
    end
  end

  // Timeout counter and sticky error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign done_to        = 1'b0;
  assign err            = 1'b0;
`endif

  assign done      = done_ok || done_to;
  assign resp_data = done_ok ? mem_rdata : 32'hFFFF_FFFF;

  // Next-state logic: round-robin pick in IDLE, return to IDLE on completion or abandoned request
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          state_d = last_grant_q ? GRANT0 : GRANT1;
        end else if (m0_valid) begin
          state_d = GRANT0;
        end else if (m1_valid) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (!sel_valid) begin
          state_d = IDLE;
        end else if (done) begin
          state_d      = IDLE;
          last_grant_d = gnt_sel;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and round-robin pointer; reset makes master 0 win the first tie
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Slave bus mux: idle bus shows master 0 address/data with no byte enables
  assign mem_valid = gnt_active && sel_valid;
  assign mem_addr  = gnt_sel ? m1_addr : m0_addr;
  assign mem_wdata = gnt_sel ? m1_wdata : m0_wdata;
  assign mem_wstrb = !gnt_active ? 4'b0000 : (gnt_sel ? m1_wstrb : m0_wstrb);
  assign mem_insn  = (state_q == GRANT0) && m0_insn;

  // Response steering: only the granted master can see ready or data
  assign m0_ready = done && (state_q == GRANT0);
  assign m1_ready = done && (state_q == GRANT1);
  assign m0_rdata = m0_ready ? resp_data : 32'h0;
  assign m1_rdata = m1_ready ? resp_data : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_valid, m0_ready, m0_insn;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        mem_valid, mem_insn, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          m;
    logic [31:0] d;
  } exp_t;
  exp_t sb_q[$];

  bit          slave_en;
  int          slave_lat;
  bit          use_ovr;
  logic [31:0] ovr_data;
  bit          ok0, ok1;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_insn(m0_insn), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .mem_valid(mem_valid), .mem_insn(mem_insn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int m, input logic [31:0] d);
    exp_t e;
    e.m = m;
    e.d = d;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for master m's ready pulse, then drop its request
  task automatic wait_done(input int m, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if ((m == 0 && m0_ready) || (m == 1 && m1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clock); #1;
    if (m == 0) m0_valid = 1'b0;
    else m1_valid = 1'b0;
  endtask

  // Slave: after slave_lat cycles of mem_valid it returns one ready pulse
  initial begin
    int          cnt;
    bit          seen;
    logic [31:0] data;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clock);
      seen = mem_valid && !mem_ready && slave_en;
      data = use_ovr ? ovr_data : (mem_addr ^ K);
      @(posedge clock); #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        cnt = 0;
      end else if (seen) begin
        cnt++;
        if (cnt >= slave_lat) begin
          mem_ready = 1'b1;
          mem_rdata = data;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: every ready pulse must match the head of the scoreboard
  always @(negedge clock) begin
    if (m0_ready || m1_ready) begin
      check("one_ready", {31'b0, m0_ready && m1_ready}, 32'h0);
      if (sb_q.size() == 0) begin
        check("unexpected_ready", {30'b0, m1_ready, m0_ready}, 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_master", m1_ready ? 32'd1 : 32'd0, e.m);
        check("sb_rdata", m1_ready ? m1_rdata : m0_rdata, e.d);
        check("idle_rdata_zero", m1_ready ? m0_rdata : m1_rdata, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit;
    reset = 1'b1;
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0; m0_insn = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    slave_en = 1; slave_lat = 1; use_ovr = 0; ovr_data = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_mem_valid", {31'b0, mem_valid}, 0);
    check("rst_m0_ready", {31'b0, m0_ready}, 0);
    check("rst_m1_ready", {31'b0, m1_ready}, 0);
    check("rst_err", {31'b0, err}, 0);
    @(negedge clock);
    reset = 1'b0;

    // m0 read, one-cycle slave, fixed data
    @(posedge clock); #1;
    use_ovr = 1; ovr_data = 32'h1234_5678;
    m0_addr = 32'h0000_0400; m0_valid = 1;
    push(0, 32'h1234_5678);
    @(negedge clock);
    check("t1_c0_valid", {31'b0, mem_valid}, 0);
    @(negedge clock);
    check("t1_c1_valid", {31'b0, mem_valid}, 1);
    check("t1_c1_addr", mem_addr, 32'h0000_0400);
    @(negedge clock);
    check("t1_c2_m0_ready", {31'b0, m0_ready}, 1);
    check("t1_c2_m1_ready", {31'b0, m1_ready}, 0);
    @(posedge clock); #1;
    m0_valid = 0; use_ovr = 0;
    repeat (2) @(posedge clock);

    // Simultaneous pairs right after reset: m0, m1, then m0, m1 again
    #1 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("t2_no_grant_at_release", {31'b0, mem_valid}, 0);
    m0_addr = 32'h0000_1000; m1_addr = 32'h0000_1100;
    m0_valid = 1; m1_valid = 1;
    push(0, 32'h0000_1000 ^ K);
    push(1, 32'h0000_1100 ^ K);
    fork
      wait_done(0, 20, ok0);
      wait_done(1, 40, ok1);
    join
    check("t2_done0", {31'b0, ok0}, 1);
    check("t2_done1", {31'b0, ok1}, 1);
    @(posedge clock); #1;
    m0_addr = 32'h0000_1200; m1_addr = 32'h0000_1300;
    m0_valid = 1; m1_valid = 1;
    push(0, 32'h0000_1200 ^ K);
    push(1, 32'h0000_1300 ^ K);
    fork
      wait_done(0, 20, ok0);
      wait_done(1, 40, ok1);
    join
    check("t2b_done0", {31'b0, ok0}, 1);
    check("t2b_done1", {31'b0, ok1}, 1);
    @(posedge clock); #1;

    // m1 partial write while m0 idle but showing full strobes
    m0_addr = 32'hDEAD_0000; m0_wstrb = 4'hF; m0_insn = 1;
    m1_addr = 32'h0001_0000; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'b0011; m1_valid = 1;
    push(1, 32'h0001_0000 ^ K);
    @(negedge clock);
    check("t3_idle_wstrb", {28'b0, mem_wstrb}, 0);
    check("t3_idle_addr", mem_addr, 32'hDEAD_0000);
    @(negedge clock);
    check("t3_g1_wstrb", {28'b0, mem_wstrb}, 32'h3);
    check("t3_g1_addr", mem_addr, 32'h0001_0000);
    check("t3_g1_wdata", mem_wdata, 32'hCAFE_F00D);
    check("t3_g1_insn", {31'b0, mem_insn}, 0);
    wait_done(1, 20, ok1);
    check("t3_done1", {31'b0, ok1}, 1);
    @(negedge clock);
    check("t3_after_wstrb", {28'b0, mem_wstrb}, 0);
    m0_wstrb = 0; m0_insn = 0;

    // Reset in the middle of GRANT0
    slave_en = 0;
    @(posedge clock); #1;
    m0_addr = 32'h0000_2000; m0_valid = 1;
    @(negedge clock);
    @(negedge clock);
    check("t4_g0_valid", {31'b0, mem_valid}, 1);
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check("t4_async_valid", {31'b0, mem_valid}, 0);
    check("t4_async_m0_ready", {31'b0, m0_ready}, 0);
    m0_valid = 0;
    @(negedge clock);
    reset = 1'b0;
    slave_en = 1;
    repeat (3) @(negedge clock);

    // m0 abandons its request; pending m1 gets the bus next
    slave_en = 0;
    @(posedge clock); #1;
    m0_addr = 32'h0000_3000; m1_addr = 32'h0000_4000;
    m0_valid = 1; m1_valid = 1;
    @(negedge clock);
    @(negedge clock);
    check("t5_g0_valid", {31'b0, mem_valid}, 1);
    check("t5_g0_addr", mem_addr, 32'h0000_3000);
    @(posedge clock); #1;
    m0_valid = 0;
    @(negedge clock);
    check("t5_drop_valid", {31'b0, mem_valid}, 0);
    @(negedge clock);
    check("t5_idle_valid", {31'b0, mem_valid}, 0);
    slave_en = 1;
    push(1, 32'h0000_4000 ^ K);
    @(negedge clock);
    check("t5_g1_valid", {31'b0, mem_valid}, 1);
    check("t5_g1_addr", mem_addr, 32'h0000_4000);
    wait_done(1, 20, ok1);
    check("t5_done1", {31'b0, ok1}, 1);

`ifdef MEM_ARBITER_TIMEOUT_EN
    // Slave never answers: abort on grant cycle 16, then m1 completes normally
    slave_en = 0;
    @(posedge clock); #1;
    m0_addr = 32'h0000_5000; m0_valid = 1;
    push(0, 32'hFFFF_FFFF);
    @(negedge clock);
    hit = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (m0_ready) begin
        hit = k;
        break;
      end
    end
    check("t6_timeout_cycle", hit, 16);
    @(posedge clock); #1;
    m0_valid = 0;
    check("t6_err_set", {31'b0, err}, 1);
    slave_en = 1;
    @(posedge clock); #1;
    m1_addr = 32'h0000_6000; m1_valid = 1;
    push(1, 32'h0000_6000 ^ K);
    wait_done(1, 20, ok1);
    check("t6_done1", {31'b0, ok1}, 1);
    check("t6_err_sticky", {31'b0, err}, 1);
`else
    hit = 0;
    check("no_timeout_err", {31'b0, err}, hit);
`endif

    repeat (3) @(negedge clock);
    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
